fetch: RTL and testbench
========================

# fetch

Instruction fetch stage of the multicycle core: on `enable` it delivers the 32-bit instruction at the next program counter to decode as `pc`/`command` with a one-cycle `done` pulse. It owns the program counter, talks to instruction memory through a req/ack handshake, and keeps a one-entry prefetch buffer so sequential fetches usually complete in one cycle. It sits between write-back, which drives `enable`/`redirect`, and decode, which consumes `pc`/`command` on `done`.

## Interface
- RESET_PC, 32'h0000_0000: first sequential fetch address after reset.
- clk  in  1  clock; all state changes on posedge.
- rstn  in  1  reset, synchronous, active-low.
- enable  in  1  one-cycle start-of-fetch pulse.
- redirect  in  1  qualifies `enable`; 1 = fetch `redirect_pc`, 0 = fetch sequential pc.
- redirect_pc  in  32  branch/jump target; bits [1:0] ignored (forced 00).
- done  out  1  one-cycle pulse: `pc`/`command` valid.
- pc  out  32  address of delivered instruction; held until next `done`.
- command  out  32  delivered instruction word; held until next `done`.
- imem_req  out  1  memory request; held high until acked.
- imem_addr  out  32  byte address, [1:0]=00; stable while `imem_req`=1.
- imem_ack  in  1  request complete; `imem_rdata` valid in same cycle.
- imem_rdata  in  32  instruction word.

## Operation
- Registers: `seq_pc` (next sequential address), `buf_valid`/`buf_addr`/`buf_data` (prefetch buffer), `disc` (discard flag), output regs.
- Target T at `enable`: `redirect ? {redirect_pc[31:2],2'b00} : seq_pc`.
- Delivery of (A, D): `pc`<=A, `command`<=D, `done`<=1, `seq_pc`<=A+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), buffer invalidated; same edge starts prefetch of A+4 (state PREF, `imem_req`=1).
- States:
  - IDLE: no request outstanding. On `enable`: buffer hit (`buf_valid && buf_addr==T`) -> deliver from buffer, stay transitioning to PREF; miss -> invalidate buffer, DEMAND with `imem_addr`=T.
  - DEMAND: on ack -> deliver(T, rdata), -> PREF.
  - PREF: speculative request for `seq_pc`. Ack without enable -> fill buffer, IDLE. `enable` with T==`imem_addr`: ack same cycle -> deliver, PREF; else -> PWAIT. `enable` with T mismatch: ack same cycle -> drop data, DEMAND(T) next cycle; else `disc`=1, -> DRAIN.
  - PWAIT: on ack -> deliver, PREF.
  - DRAIN: on ack -> drop data, `disc`=0, DEMAND(T latched).
- `enable` is legal only in IDLE/PREF (i.e. after a `done`); in other states it is ignored.
- Reset: all state cleared; fetch waits in IDLE for first `enable`.

## Timing
- Reset values: `done`=0, `pc`=0, `command`=0, `imem_req`=0, `imem_addr`=0, `seq_pc`=RESET_PC, `buf_valid`=0, `disc`=0, state IDLE.
- Hit: `enable` at cycle t -> `done` at t+1; `imem_req` for next pc at t+1.
- Miss: `enable` at t -> `imem_req` at t+1; ack at t+1+L (L>=0) -> `done` at t+2+L.
- Memory may ack in the first cycle `imem_req` is high; `imem_req` drops the cycle after ack unless a new request starts on that edge (address changes on the same edge).
- `done` never asserted two consecutive cycles; `pc`/`command` change only with `done`.
- Reset mid-request: `imem_req` drops next cycle; late acks after reset ignored while IDLE.

## Structure
- Shared package `core_pkg`: fetch state enum (IDLE, DEMAND, PREF, PWAIT, DRAIN), `INST_BYTES`=4, `NOP_WORD`=32'h0.
- One sub-module: `prefetch_buf` (valid/addr/data, fill, invalidate, hit compare).

## Test plan
- Reset, RESET_PC=32'h100, `enable` redirect=0, ack after 2 cycles with 32'hDEAD_BEEF -> `done` 4 cycles after enable, `pc`=32'h100, `command`=32'hDEAD_BEEF; `imem_req` rises for 32'h104.
- Let prefetch of 32'h104 fill, then `enable` redirect=0 -> `done` next cycle, `pc`=32'h104, no new demand request.
- `enable` redirect=1 `redirect_pc`=32'h203 while prefetch of 32'h108 pending, ack 3 cycles later -> data dropped, `imem_addr`=32'h200 requested next, `done` with `pc`=32'h200.
- `enable` redirect=0 while matching prefetch pending -> PWAIT, single request only, `done` the cycle after ack.
- Redirect to 32'hFFFF_FFFC -> delivered, prefetch `imem_addr`=32'h0; next sequential fetch gives `pc`=0.
- `rstn` low during DEMAND -> `imem_req`=0, `done`=0 next cycle; late ack produces no `done`.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the core pipeline.
// Holds the fetch state enum, instruction size and NOP word.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEMAND,
    PREF,
    PWAIT,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] INST_BYTES = 32'd4;
  localparam logic [31:0] NOP_WORD   = 32'h0;

  function automatic logic [31:0] align(
    input logic [31:0] a
  );
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// prefetch_buf: one-entry instruction buffer for fetch.
// Ports: fill/inval controls, fill addr/data, lookup addr -> hit, data.
import core_pkg::*;

module prefetch_buf (
  input  logic        clk,
  input  logic        rstn,
  input  logic        fill,
  input  logic        inval,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_data,
  input  logic [31:0] look_addr,
  output logic        hit,
  output logic [31:0] data
);

  logic        valid;
  logic [31:0] addr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= NOP_WORD;
    end else if (fill) begin
      valid <= 1'b1;
      addr  <= fill_addr;
      data  <= fill_data;
    end else if (inval) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (addr == look_addr);

endmodule

// File: rtl/fetch.sv
// fetch: instruction fetch stage with pc, imem req/ack and prefetch.
// Ports: enable/redirect in; done/pc/command out; imem req/addr/ack/rdata.
import core_pkg::*;

module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        done,
  output logic [31:0] pc,
  output logic [31:0] command,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata
);

  fetch_state_t state, state_n;

  logic [31:0] seq_pc;
  logic [31:0] tgt, tgt_n;
  logic        disc, disc_n;
  logic [31:0] t_addr;
  logic        hit;
  logic [31:0] buf_data;

  logic        dlv;
  logic [31:0] dlv_addr;
  logic [31:0] dlv_data;
  logic        ld;
  logic [31:0] addr_n;
  logic        fill;
  logic        inval;

  assign t_addr   = redirect ? align(redirect_pc) : seq_pc;
  assign imem_req = (state != IDLE);

  prefetch_buf u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .fill      (fill),
    .inval     (inval | dlv),
    .fill_addr (imem_addr),
    .fill_data (imem_rdata),
    .look_addr (t_addr),
    .hit       (hit),
    .data      (buf_data)
  );

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    dlv      = 1'b0;
    dlv_addr = imem_addr;
    dlv_data = imem_rdata;
    ld       = 1'b0;
    addr_n   = imem_addr;
    tgt_n    = tgt;
    disc_n   = disc;
    fill     = 1'b0;
    inval    = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          if (hit) begin
            dlv      = 1'b1;
            dlv_addr = t_addr;
            dlv_data = buf_data;
            state_n  = PREF;
          end else begin
            inval   = 1'b1;
            ld      = 1'b1;
            addr_n  = t_addr;
            state_n = DEMAND;
          end
        end
      end
      DEMAND: begin
        if (imem_ack) begin
          dlv     = 1'b1;
          state_n = PREF;
        end
      end
      PREF: begin
        if (enable) begin
          if (t_addr == imem_addr) begin
            if (imem_ack) dlv     = 1'b1;
            else          state_n = PWAIT;
          end else begin
            tgt_n = t_addr;
            if (imem_ack) begin
              ld      = 1'b1;
              addr_n  = t_addr;
              state_n = DEMAND;
            end else begin
              // speculative data still in flight; drop it on arrival
              disc_n  = 1'b1;
              state_n = DRAIN;
            end
          end
        end else if (imem_ack) begin
          fill    = 1'b1;
          state_n = IDLE;
        end
      end
      PWAIT: begin
        if (imem_ack) begin
          dlv     = 1'b1;
          state_n = PREF;
        end
      end
      DRAIN: begin
        if (imem_ack && disc) begin
          disc_n  = 1'b0;
          ld      = 1'b1;
          addr_n  = tgt;
          state_n = DEMAND;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      seq_pc    <= RESET_PC;
      imem_addr <= '0;
      tgt       <= '0;
      disc      <= 1'b0;
      done      <= 1'b0;
      pc        <= '0;
      command   <= NOP_WORD;
    end else begin
      tgt  <= tgt_n;
      disc <= disc_n;
      done <= dlv;
      if (dlv) begin
        pc        <= dlv_addr;
        command   <= dlv_data;
        seq_pc    <= dlv_addr + INST_BYTES;
        imem_addr <= dlv_addr + INST_BYTES;
      end else if (ld) begin
        imem_addr <= addr_n;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: scoreboard bench for fetch with a latency-controlled imem.
// Stimulus pushes expected pc/command; a monitor pops on each done.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        done;
  logic [31:0] pc;
  logic [31:0] command;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  int   lat      = 2;
  logic mem_on   = 1'b1;
  logic late_ack = 1'b0;

  fetch #(.RESET_PC(32'h100)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .done        (done),
    .pc          (pc),
    .command     (command),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory responder
  initial begin
    int cnt;
    cnt        = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_on) begin
        cnt        = 0;
        imem_ack   = late_ack;
        imem_rdata = 32'hBAD0_BAD0;
      end else if (imem_req && cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        cnt        = 0;
      end else begin
        imem_ack = 1'b0;
        cnt      = imem_req ? cnt + 1 : 0;
      end
    end
  end

  // monitor
  initial begin
    logic        prev;
    logic [63:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn && done) begin
        if (prev) chk("done_twice", 32'd1, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_done_pc", pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pc", pc, e[63:32]);
          chk("command", command, e[31:0]);
        end
      end
      prev = rstn && done;
    end
  end

  task automatic push(
    input logic [31:0] a,
    input logic [31:0] d
  );
    exp_q.push_back({a, d});
  endtask

  task automatic issue(
    input logic        r,
    input logic [31:0] a
  );
    @(posedge clk);
    #1;
    enable      = 1'b1;
    redirect    = r;
    redirect_pc = a;
    @(posedge clk);
    #1;
    enable   = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic wait_done(
    input  int lim,
    output int n
  );
    n = 1;
    while (!done && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int k;
    rstn        = 1'b0;
    enable      = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_command", command, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    rstn = 1'b1;

    // miss from reset pc, ack after 2 cycles
    push(32'h100, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0);
    wait_done(20, n);
    chk("miss_latency", n, 32'd4);
    chk("pref_req", {31'd0, imem_req}, 32'd1);
    chk("pref_addr", imem_addr, 32'h104);

    // prefetch fills, then buffer hit
    repeat (5) @(posedge clk);
    #1;
    chk("fill_idle_req", {31'd0, imem_req}, 32'd0);
    lat = 4;
    push(32'h104, 32'hC0DE_0104);
    issue(1'b0, 32'h0);
    wait_done(20, n);
    chk("hit_latency", n, 32'd1);
    chk("hit_next_addr", imem_addr, 32'h108);

    // redirect while prefetch of 0x108 pending
    push(32'h200, 32'hC0DE_0200);
    issue(1'b1, 32'h203);
    k = 0;
    while (imem_addr == 32'h108 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    wait_done(30, n);

    // sequential enable against matching pending prefetch
    push(32'h204, 32'hC0DE_0204);
    issue(1'b0, 32'h0);
    chk("pwait_addr", imem_addr, 32'h204);
    chk("pwait_req", {31'd0, imem_req}, 32'd1);
    wait_done(20, n);
    chk("pwait_latency", n, 32'd4);
    chk("pwait_next_addr", imem_addr, 32'h208);

    // wrap at top of address space
    push(32'hFFFF_FFFC, 32'hC0DE_FFFC);
    issue(1'b1, 32'hFFFF_FFFE);
    wait_done(30, n);
    chk("wrap_pref_addr", imem_addr, 32'h0);
    push(32'h0, 32'hC0DE_0000);
    issue(1'b0, 32'h0);
    wait_done(20, n);
    chk("wrap_latency", n, 32'd4);

    // reset during demand, then a late ack
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_idle", {31'd0, imem_req}, 32'd0);
    mem_on = 1'b0;
    issue(1'b1, 32'h300);
    chk("dem_req", {31'd0, imem_req}, 32'd1);
    chk("dem_addr", imem_addr, 32'h300);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rstn     = 1'b1;
    late_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    late_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_ack_done", {31'd0, done}, 32'd0);
    chk("late_ack_pc", pc, 32'd0);

    // zero-latency ack after reset
    mem_on = 1'b1;
    lat    = 0;
    push(32'h100, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0);
    wait_done(20, n);
    chk("lat0_latency", n, 32'd2);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
